// File: rtl/bootrom_pkg.sv
// Shared types and default sizes for the boot ROM front-end controller.
package bootrom_pkg;

    localparam int ROM_WORDS_DEF  = 2048;
    localparam int ROM_ADDR_W_DEF = 13;
    localparam int ROM_IDX_W      = 11;

    typedef enum logic [1:0] {
        IDLE      = 2'd0,
        CPU_WAIT  = 2'd1,
        CPU_WACK  = 2'd2,
        SCAN_WAIT = 2'd3
    } bootrom_state_t;

endpackage

// File: rtl/bootrom_scanner.sv
// Integrity scanner datapath: word index, running checksum and the
// busy/done/ok flags. The controller FSM tells it when a ROM word is
// available (advance) and whether that word is the last one (finish).
module bootrom_scanner
    import bootrom_pkg::*;
#(
    parameter int          ROM_WORDS    = ROM_WORDS_DEF,
    parameter int          IDX_W        = ROM_IDX_W,
    parameter logic [31:0] EXPECTED_SUM = 32'h0000_0000,
    parameter int          AUTO_SCAN    = 1
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic             advance,
    input  logic             finish,
    input  logic [31:0]      word,
    output logic [IDX_W-1:0] idx,
    output logic             last,
    output logic             busy,
    output logic             done,
    output logic             ok,
    output logic [31:0]      sum
);

    logic        auto_pend;
    logic [31:0] sum_next;

    assign sum_next = sum + word;
    assign last     = (idx == IDX_W'(ROM_WORDS - 1));

    // Start (explicit or the one-shot auto start after reset) is only
    // honoured while no scan is running; the index wraps only on finish.
    always_ff @(posedge clk) begin
        if (reset) begin
            auto_pend <= (AUTO_SCAN != 0);
            idx       <= '0;
            sum       <= '0;
            busy      <= 1'b0;
            done      <= 1'b0;
            ok        <= 1'b0;
        end else if (!busy && (start || auto_pend)) begin
            auto_pend <= 1'b0;
            idx       <= '0;
            sum       <= '0;
            busy      <= 1'b1;
            done      <= 1'b0;
            ok        <= 1'b0;
        end else if (advance) begin
            sum <= sum_next;
            if (finish) begin
                idx  <= '0;
                busy <= 1'b0;
                done <= 1'b1;
                ok   <= (sum_next == EXPECTED_SUM);
            end else begin
                idx <= idx + IDX_W'(1);
            end
        end
    end

endmodule

// File: rtl/bootrom_ctrl.sv
// Boot ROM front-end: arbitrates the single ROM read port between the CPU
// (strict priority) and the integrity scanner (idle cycles only).
// Optional build macro BOOTROM_WRERR_EN adds a sticky wr_err output that
// flags CPU write attempts to the ROM.
//
// state     | meaning
// ----------+-----------------------------------------------------------
// IDLE      | issue CPU read, accept CPU write, or issue a scan read
// CPU_WAIT  | ROM data for the CPU read is on rom_rdata; ack the CPU
// CPU_WACK  | ack a CPU write attempt with zero data, no ROM access
// SCAN_WAIT | ROM data for the scanner is on rom_rdata; accumulate it
module bootrom_ctrl
    import bootrom_pkg::*;
#(
    parameter int          ROM_WORDS    = ROM_WORDS_DEF,
    parameter int          ADDR_W       = ROM_ADDR_W_DEF,
    parameter logic [31:0] EXPECTED_SUM = 32'h0000_0000,
    parameter int          AUTO_SCAN    = 1
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              cpu_valid,
    input  logic [ADDR_W-1:0] cpu_addr,
    input  logic [3:0]        cpu_wstrb,
    output logic              cpu_ready,
    output logic [31:0]       cpu_rdata,
    output logic              rom_enable,
    output logic [ADDR_W-1:0] rom_addr,
    input  logic [31:0]       rom_rdata,
    input  logic              scan_start,
    output logic              scan_busy,
    output logic              scan_done,
    output logic              scan_ok,
    output logic [31:0]       scan_sum
`ifdef BOOTROM_WRERR_EN
    ,
    output logic              wr_err
`endif
);

    localparam int IDX_W = $clog2(ROM_WORDS);

    bootrom_state_t    state;
    bootrom_state_t    state_nx;
    logic [IDX_W-1:0]  scan_idx;
    logic              scan_last;
    logic              scan_adv;
    logic [ADDR_W-1:0] scan_addr;

    assign scan_adv  = (state == SCAN_WAIT);
    assign scan_addr = ADDR_W'({scan_idx, 2'b00});

    // The ack and its data come straight off the state register and the
    // registered ROM output, giving one-cycle read latency.
    assign cpu_ready = (state == CPU_WAIT) || (state == CPU_WACK);
    assign cpu_rdata = (state == CPU_WAIT) ? rom_rdata : 32'h0;

    // State register.
    always_ff @(posedge clk) begin
        if (reset) begin
            state <= IDLE;
        end else begin
            state <= state_nx;
        end
    end

    // Next state and ROM port drive; held quiet while reset is asserted.
    always_comb begin
        state_nx   = state;
        rom_enable = 1'b0;
        rom_addr   = '0;
        if (!reset) begin
            case (state)
                IDLE: begin
                    if (cpu_valid) begin
                        if (cpu_wstrb == 4'b0000) begin
                            rom_enable = 1'b1;
                            rom_addr   = cpu_addr;
                            state_nx   = CPU_WAIT;
                        end else begin
                            state_nx = CPU_WACK;
                        end
                    end else if (scan_busy) begin
                        rom_enable = 1'b1;
                        rom_addr   = scan_addr;
                        state_nx   = SCAN_WAIT;
                    end
                end
                CPU_WAIT:  state_nx = IDLE;
                CPU_WACK:  state_nx = IDLE;
                SCAN_WAIT: state_nx = IDLE;
                default:   state_nx = IDLE;
            endcase
        end
    end

    bootrom_scanner #(
        .ROM_WORDS    (ROM_WORDS),
        .IDX_W        (IDX_W),
        .EXPECTED_SUM (EXPECTED_SUM),
        .AUTO_SCAN    (AUTO_SCAN)
    ) u_scanner (
        .clk     (clk),
        .reset   (reset),
        .start   (scan_start),
        .advance (scan_adv),
        .finish  (scan_adv && scan_last),
        .word    (rom_rdata),
        .idx     (scan_idx),
        .last    (scan_last),
        .busy    (scan_busy),
        .done    (scan_done),
        .ok      (scan_ok),
        .sum     (scan_sum)
    );

`ifdef BOOTROM_WRERR_EN
    // Sticky debug flag: any write attempt to the ROM, cleared by reset only.
    always_ff @(posedge clk) begin
        if (reset) begin
            wr_err <= 1'b0;
        end else if (state == CPU_WACK) begin
            wr_err <= 1'b1;
        end
    end
`endif

endmodule

// File: doc/bootrom_ctrl.md
Name: bootrom_ctrl

Overview:
Front-end controller for the 8KB read-only boot BRAM at 0x40000. It shares the single ROM read port between the CPU bus and a built-in integrity scanner. The scanner sums all 2048 words and compares the result against an expected checksum. The CPU has strict priority; the scanner runs in idle cycles only. Address decode of the 0x40000 window is done upstream; this block sees the local byte address only.

Parameters:
ROM_WORDS, 2048, number of 32-bit ROM words
ADDR_W, 13, byte-address width of the ROM window
EXPECTED_SUM, 32'h0000_0000, expected modulo-2^32 sum of all ROM words
AUTO_SCAN, 1, 1 = scan starts automatically after reset deasserts

Ports:
clk  in  1  system clock; the only clock
reset  in  1  synchronous reset, active-high
cpu_valid  in  1  CPU request (picorv32 native; held until cpu_ready)
cpu_addr  in  ADDR_W  CPU byte address within the ROM window
cpu_wstrb  in  4  byte strobes; non-zero means a write attempt
cpu_ready  out  1  single-cycle response strobe
cpu_rdata  out  32  read data; valid only while cpu_ready=1
rom_enable  out  1  ROM read enable for the issue cycle
rom_addr  out  ADDR_W  ROM byte address; bits [1:0] are ignored by the ROM
rom_rdata  in  32  registered ROM output, valid one cycle after rom_enable
scan_start  in  1  pulse: (re)start the integrity scan
scan_busy  out  1  scan in progress
scan_done  out  1  sticky: scan completed
scan_ok  out  1  sticky: scan_done and scan_sum == EXPECTED_SUM
scan_sum  out  32  final or running checksum

Behaviour:
- Reset values:
  - cpu_ready=0, cpu_rdata=0, rom_enable=0, rom_addr=0.
  - scan_busy=0, scan_done=0, scan_ok=0, scan_sum=0.
  - Internal state: FSM=IDLE, scan index=0.
  - If AUTO_SCAN=1, scan_busy rises in the first cycle after reset deasserts.
- FSM states: IDLE, CPU_WAIT, CPU_WACK, SCAN_WAIT.
- IDLE:
  - cpu_valid and cpu_wstrb==0: rom_enable=1, rom_addr=cpu_addr, go to CPU_WAIT.
  - cpu_valid and cpu_wstrb!=0: no ROM access, go to CPU_WACK.
  - Else if scan_busy: rom_enable=1, rom_addr={idx,2'b00}, go to SCAN_WAIT.
  - Else stay in IDLE.
- CPU_WAIT: cpu_ready=1, cpu_rdata=rom_rdata, return to IDLE. Read latency is cpu_valid in cycle N -> cpu_ready in cycle N+1. A cpu_valid still high in this cycle belongs to the same transaction and is not reissued.
- CPU_WACK: cpu_ready=1, cpu_rdata=0, return to IDLE. Write data is discarded.
- SCAN_WAIT: sum <= sum + rom_rdata (mod 2^32), idx <= idx+1, return to IDLE.
  - On idx==ROM_WORDS-1: scan_busy=0, scan_done=1, scan_ok=(new sum==EXPECTED_SUM).
  - A cpu_valid arriving here is served from IDLE in the next cycle, so worst-case CPU latency is 2 cycles.
- Scan throughput: 2 cycles per word when the CPU is idle. An uncontended scan takes 4096 cycles.
- Outside CPU_WAIT and CPU_WACK, cpu_rdata is driven to 0.
- rom_enable and rom_addr are combinational from the state and inputs. Everything else is registered.
- scan_start:
  - While idle or done: clears sum, idx, scan_done and scan_ok, and sets scan_busy.
  - While scan_busy=1: ignored.
  - Simultaneous with reset: reset wins.
- Reset mid-operation:
  - Aborts any transaction; no cpu_ready is issued for it.
  - Clears the scan. With AUTO_SCAN=1 the scan restarts from word 0.
- The scan index wraps only through the done path; it never wraps silently.

Optional Feature:
BOOTROM_WRERR_EN
- Defined: adds output wr_err (1 bit, reset 0). It is a sticky flag set in CPU_WACK and cleared only by reset. It is intended as a debug indicator of writes to ROM.
- Undefined: the port is absent and writes are silently acknowledged as above.

Decomposition:
- Package bootrom_pkg contains:
  - FSM state enum (IDLE, CPU_WAIT, CPU_WACK, SCAN_WAIT).
  - ROM_WORDS_DEF=2048, ROM_ADDR_W_DEF=13, ROM_IDX_W=11.
- Sub-module bootrom_scanner holds the index counter, accumulator, busy/done/ok flags and the start/advance/finish inputs.
- bootrom_ctrl keeps the FSM and the port muxing.

Test Plan:
1. ROM word i = i, AUTO_SCAN=1, no CPU traffic -> scan_done after 4096 cycles; scan_sum=0x001FFC00; scan_ok=1 with EXPECTED_SUM=0x001FFC00.
2. Same image; CPU reads cpu_addr=0x0010 repeatedly during the scan -> each cpu_ready arrives ≤2 cycles after cpu_valid with cpu_rdata=0x00000004; final scan_sum is still 0x001FFC00 (no word skipped or double-counted).
3. CPU write with cpu_wstrb=4'hF to 0x0100 from IDLE -> cpu_ready next cycle, cpu_rdata=0, rom_enable stays 0; wr_err=1 when BOOTROM_WRERR_EN is defined.
4. reset asserted for 1 cycle at scan index 1000 -> all outputs return to reset values; scan restarts at word 0; final scan_sum=0x001FFC00.
5. EXPECTED_SUM=0x12345678 -> scan_done=1, scan_ok=0. Then scan_start pulse -> scan_done clears and the rescan completes with the same sum. A scan_start pulse issued while scan_busy=1 is ignored (sum unaffected).
